game_of_life_host: RTL and testbench
====================================

# game_of_life_host

Host-side sequencer that sits directly upstream of the GameOfLifeInterface serial port and drives its `run`, `write_read_not` and `serial_in` pins while consuming its `serial_out` pin. It accepts a full parallel board and a generation count through a valid/ready command channel, then performs three phases in order: serially loads the board, runs the core for the requested number of cycles, and serially reads back the evolved board. It returns the result on a valid/ready response channel, so the rest of the design never handles the bit-serial protocol.

## Interface
- `ROW`, default 6: board rows; must match the interface instance.
- `COL`, default 6: board columns; must match the interface instance. N = ROW*COL below.
- `GEN_W`, default 8: width of the generation count.

Ports:
- `clk` in 1: single clock, shared with GameOfLifeInterface.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_board` in N: initial board; bit k = cell k (k = r*COL+c).
- `cmd_gens` in GEN_W: number of cycles to hold `run` high.
- `res_valid` out 1: result board available.
- `res_ready` in 1: consumer accepts the result.
- `res_board` out N: board read back; bit k = cell k.
- `busy` out 1: state != IDLE.
- `run` out 1: to interface `run`.
- `write_read_not` out 1: to interface `write_read_not`.
- `serial_in` out 1: to interface `serial_in`.
- `serial_out` in 1: from interface `serial_out`.

## Operation
- All outputs are registered. Reset values: `cmd_ready`=1, `res_valid`=0, `res_board`=0, `busy`=0, `run`=0, `write_read_not`=1, `serial_in`=0.
- Internal registers: latched board (N), latched gens (GEN_W), bit counter (width ceil(log2(N+2))), gen counter (GEN_W).
- **IDLE**
  - On `cmd_valid && cmd_ready`, latch `cmd_board` and `cmd_gens`, clear the counters, and go to LOAD.
  - `cmd_valid` in any other state is ignored; no queuing.
- **LOAD**, N cycles:
  - Drive `run`=0 and `write_read_not`=1.
  - In LOAD cycle k (k = 0..N-1), drive `serial_in` = board[k], LSB first. The interface shift register places the bit sent in cycle k at index k.
  - After the last bit, go to RUN if gens > 0, otherwise go to READ.
- **RUN**, exactly gens cycles:
  - Drive `run`=1 and `write_read_not`=1.
  - Then go to READ.
- **READ**, N+1 cycles:
  - Drive `run`=0 and `write_read_not`=0.
  - The interface emits bit k registered on its k-th read edge.
  - On read edges 1..N, the host samples `serial_out` into `res_board[k-1]`. The first read edge's sample is discarded.
  - Then go to DONE.
- **DONE**
  - `res_valid`=1, and `res_board` is held stable.
  - `run`=0 and `write_read_not`=1 (idle values).
  - On `res_valid && res_ready`, go to IDLE; `cmd_ready` rises on the next cycle.
- **gens=0**: LOAD→READ directly. The interface switches from write to read mode without reloading, so `res_board` equals `cmd_board` exactly.
- **Reset mid-operation**
  - The transaction is aborted and no `res_valid` is produced. Outputs return to their reset values on the next edge.
  - The interface itself has no reset. Every transaction fully rewrites all N shift bits and always changes mode, so the next command completes correctly regardless of the interface state left behind.
- **Counters**: the gens count is unsigned. The maximum 2^GEN_W-1 is legal. Counters saturate internally and do not wrap.

## Timing
- Accept edge E0. LOAD bit k is on `serial_in` after edge E(k).
- `run`=1 is visible after edges E(N) through E(N+gens-1).
- READ mode is visible from after E(N+gens). `res_board[k]` is captured at E(N+gens+2+k).
- `res_valid` rises after edge E(2N+gens+1). Command-to-result latency is therefore 2N+gens+1 cycles: 73 for N=36, gens=0.
- Back-to-back operation: result accepted at edge Ea means `cmd_ready`=1 after Ea, and a new command can be accepted at Ea+1.
- Backpressure: `res_valid` and `res_board` are held indefinitely while `res_ready`=0.

## Test plan
- Reset: assert `rst` 3 cycles with random inputs -> all outputs at reset values. After release, `cmd_ready`=1 and `busy`=0.
- Round trip: `cmd_board`=36'h9_A5C3_0F17, gens=0 -> `res_board`=36'h9_A5C3_0F17, with `res_valid` exactly 73 cycles after accept; check `serial_in` bit order LSB first.
- Still life: 2x2 block, `cmd_board`=36'h6180, gens=7 -> `res_board`=36'h6180 after 80 cycles; `run` high exactly 7 cycles.
- Empty board and golden model: `cmd_board`=0, gens=3 -> 0. A random board with gens=1..4 must match a software GameOfLife-core model driven with the same run-cycle count.
- Handshake: hold `res_ready`=0 for 10 cycles -> `res_valid` and `res_board` stable throughout. A `cmd_valid` pulse while busy is ignored (no second result).
- Reset mid-LOAD at bit 17, then command 36'h6180 with gens=2 -> correct result 36'h6180 and no spurious `res_valid` from the aborted command.

Source files
------------

// File: rtl/game_of_life_host_if.sv
// Command/response channel between a board producer and game_of_life_host.
// The master side issues boards and generation counts and collects evolved boards.
interface game_of_life_host_if #(
  parameter int ROW   = 6,
  parameter int COL   = 6,
  parameter int GEN_W = 8
);
  localparam int N = ROW * COL;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [N-1:0]     cmd_board;
  logic [GEN_W-1:0] cmd_gens;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_board;

  modport master (
    output cmd_valid, cmd_board, cmd_gens, res_ready,
    input  cmd_ready, res_valid, res_board
  );

  modport slave (
    input  cmd_valid, cmd_board, cmd_gens, res_ready,
    output cmd_ready, res_valid, res_board
  );
endinterface

// File: rtl/game_of_life_host.sv
// Host-side sequencer for the GameOfLifeInterface serial port: serially loads a board,
// runs the core for the requested generations, then serially reads the result back.
module game_of_life_host #(
  parameter int ROW   = 6,
  parameter int COL   = 6,
  parameter int GEN_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  game_of_life_host_if.slave  host,
  output logic                busy,
  output logic                run,
  output logic                write_read_not,
  output logic                serial_in,
  input  logic                serial_out
);
  localparam int N     = ROW * COL;
  localparam int CNT_W = $clog2(N + 2);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);
  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, DONE} state_t;

  state_t           state, state_next;
  logic [N-1:0]     board, board_next;
  logic [GEN_W-1:0] gens, gens_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [GEN_W-1:0] gen_cnt, gen_cnt_next;
  logic             cmd_ready, cmd_ready_next;
  logic             res_valid, res_valid_next;
  logic [N-1:0]     res_board, res_board_next;
  logic             busy_next, run_next, wrn_next, serial_in_next;

  assign host.cmd_ready = cmd_ready;
  assign host.res_valid = res_valid;
  assign host.res_board = res_board;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      board          <= '0;
      gens           <= '0;
      bit_cnt        <= '0;
      gen_cnt        <= '0;
      cmd_ready      <= 1'b1;
      res_valid      <= 1'b0;
      res_board      <= '0;
      busy           <= 1'b0;
      run            <= 1'b0;
      write_read_not <= 1'b1;
      serial_in      <= 1'b0;
    end else begin
      state          <= state_next;
      board          <= board_next;
      gens           <= gens_next;
      bit_cnt        <= bit_cnt_next;
      gen_cnt        <= gen_cnt_next;
      cmd_ready      <= cmd_ready_next;
      res_valid      <= res_valid_next;
      res_board      <= res_board_next;
      busy           <= busy_next;
      run            <= run_next;
      write_read_not <= wrn_next;
      serial_in      <= serial_in_next;
    end
  end

  // Every output is registered, so each branch computes what the pins show in the next state.
  always_comb begin
    state_next     = state;
    board_next     = board;
    gens_next      = gens;
    bit_cnt_next   = bit_cnt;
    gen_cnt_next   = gen_cnt;
    cmd_ready_next = cmd_ready;
    res_valid_next = res_valid;
    res_board_next = res_board;
    run_next       = run;
    wrn_next       = write_read_not;
    serial_in_next = serial_in;

    case (state)
      IDLE: begin
        if (host.cmd_valid && cmd_ready) begin
          state_next     = LOAD;
          board_next     = host.cmd_board;
          gens_next      = host.cmd_gens;
          bit_cnt_next   = CNT_ONE;
          gen_cnt_next   = '0;
          cmd_ready_next = 1'b0;
          run_next       = 1'b0;
          wrn_next       = 1'b1;
          serial_in_next = host.cmd_board[0];
        end
      end
      LOAD: begin
        if (bit_cnt == LAST) begin
          serial_in_next = 1'b0;
          if (gens != '0) begin
            state_next   = RUN;
            run_next     = 1'b1;
            gen_cnt_next = GEN_ONE;
          end else begin
            state_next   = READ;
            wrn_next     = 1'b0;
            bit_cnt_next = '0;
          end
        end else begin
          serial_in_next = board[bit_cnt];
          bit_cnt_next   = bit_cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (gen_cnt >= gens) begin
          state_next   = READ;
          run_next     = 1'b0;
          wrn_next     = 1'b0;
          bit_cnt_next = '0;
        end else if (gen_cnt != GEN_MAX) begin
          gen_cnt_next = gen_cnt + GEN_ONE;
        end
      end
      READ: begin
        // The interface needs one read edge to present its first bit, so that sample is dropped.
        if (bit_cnt != '0) begin
          res_board_next[bit_cnt - CNT_ONE] = serial_out;
        end
        if (bit_cnt == LAST) begin
          state_next     = DONE;
          res_valid_next = 1'b1;
          wrn_next       = 1'b1;
        end else begin
          bit_cnt_next = bit_cnt + CNT_ONE;
        end
      end
      DONE: begin
        if (host.res_ready) begin
          state_next     = IDLE;
          res_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end
endmodule

// File: tb/tb_game_of_life_host.sv
// Bench for game_of_life_host: a behavioural GameOfLifeInterface sits on the serial pins and
// results are compared against a grid-level Game of Life model evolved in plain loops.
module tb_game_of_life_host;
  localparam int ROW   = 6;
  localparam int COL   = 6;
  localparam int GEN_W = 8;
  localparam int N     = ROW * COL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, run, write_read_not, serial_in;
  logic serial_out = 1'b0;
  logic [N-1:0] dev_reg;
  int n_checks = 0;
  int n_fail   = 0;

  game_of_life_host_if #(.ROW(ROW), .COL(COL), .GEN_W(GEN_W)) bus();

  game_of_life_host #(.ROW(ROW), .COL(COL), .GEN_W(GEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (bus),
    .busy          (busy),
    .run           (run),
    .write_read_not(write_read_not),
    .serial_in     (serial_in),
    .serial_out    (serial_out)
  );

  always #5 clk = ~clk;

  // One Game of Life generation on a ROW x COL grid; cells beyond the edge count as dead.
  function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
    logic [N-1:0] nxt;
    int cnt;
    nxt = '0;
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROW && c + dc >= 0 && c + dc < COL)
              cnt += int'(b[(r + dr) * COL + c + dc]);
        nxt[r * COL + c] = (cnt == 3) || (cnt == 2 && b[r * COL + c] == 1'b1);
      end
    end
    return nxt;
  endfunction

  function automatic logic [N-1:0] ref_life(input logic [N-1:0] b, input int gens);
    logic [N-1:0] cur;
    cur = b;
    for (int g = 0; g < gens; g++) cur = life_step(cur);
    return cur;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [63:0] wide;
    wide = {$urandom, $urandom};
    return wide[N-1:0];
  endfunction

  // Behavioural serial port: shift in while writing, evolve while running, stream out while reading.
  always @(posedge clk) begin
    if (run === 1'b1) begin
      dev_reg <= life_step(dev_reg);
    end else if (write_read_not === 1'b1) begin
      dev_reg <= {serial_in, dev_reg[N-1:1]};
    end else begin
      serial_out <= dev_reg[0];
      dev_reg    <= {dev_reg[0], dev_reg[N-1:1]};
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one command starting at the current negedge and records what the pins did until res_valid.
  task automatic apply_command(
    input  logic [N-1:0]     board,
    input  logic [GEN_W-1:0] gens,
    input  bit               accept,
    input  int               pulse_at,
    output logic [N-1:0]     result,
    output int               latency,
    output int               run_cycles,
    output int               read_cycles,
    output logic [N-1:0]     sin_bits,
    output bit               ready_at_start,
    output bit               timed_out,
    output bit               ready_after
  );
    int cyc;
    ready_at_start = (bus.cmd_ready === 1'b1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_board  = board;
    bus.cmd_gens   = gens;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 0; run_cycles = 0; read_cycles = 0; sin_bits = '0; ready_after = 1'b0;
    while (bus.res_valid !== 1'b1 && cyc < 2000) begin
      if (cyc < N) sin_bits[cyc] = serial_in;
      if (run === 1'b1) run_cycles++;
      if (write_read_not === 1'b0) read_cycles++;
      if (cyc == pulse_at) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_board = ~board;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    timed_out = (bus.res_valid !== 1'b1);
    result    = bus.res_board;
    latency   = cyc;
    if (accept) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      ready_after = (bus.cmd_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.cmd_ready, bus.res_valid, busy, run, write_read_not, serial_in} !== 6'b100010) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got %b expected 100010",
                 {bus.cmd_ready, bus.res_valid, busy, run, write_read_not, serial_in});
      end
      n_checks++;
      if (bus.res_board !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_res_board: got %h expected 0", bus.res_board);
      end
      bus.cmd_valid = 1'($urandom);
      bus.res_ready = 1'($urandom);
      bus.cmd_board = rand_board();
      bus.cmd_gens  = GEN_W'($urandom);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL after_reset_ready_busy: got %b expected 10", {bus.cmd_ready, busy});
    end
  endtask

  task automatic test_round_trip();
    logic [N-1:0] b, res, sin;
    int lat, rc, rd;
    bit rdy, to, rdy_after;
    b = 36'h9_A5C3_0F17;
    apply_command(b, 8'd0, 1'b1, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
    n_checks++;
    if ({rdy, to} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL round_trip_handshake: got ready/timeout %b expected 10", {rdy, to});
    end
    n_checks++;
    if (res !== b) begin
      n_fail++; $display("[TB] FAIL round_trip_board: got %h expected %h", res, b);
    end
    n_checks++;
    if (lat !== 2 * N + 1) begin
      n_fail++; $display("[TB] FAIL round_trip_latency: got %0d expected %0d", lat, 2 * N + 1);
    end
    n_checks++;
    if (sin !== b) begin
      n_fail++; $display("[TB] FAIL round_trip_serial_order: got %h expected %h", sin, b);
    end
    n_checks++;
    if (rc !== 0 || rd !== N + 1) begin
      n_fail++; $display("[TB] FAIL round_trip_phases: got run %0d read %0d expected 0 and %0d", rc, rd, N + 1);
    end
    n_checks++;
    if (rdy_after !== 1'b1) begin
      n_fail++; $display("[TB] FAIL round_trip_ready_after: got %b expected 1", rdy_after);
    end
  endtask

  task automatic test_still_life();
    logic [N-1:0] res, sin;
    int lat, rc, rd;
    bit rdy, to, rdy_after;
    apply_command(36'h6180, 8'd7, 1'b1, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
    n_checks++;
    if (res !== 36'h6180 || to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL still_life_board: got %h expected 6180", res);
    end
    n_checks++;
    if (lat !== 80) begin
      n_fail++; $display("[TB] FAIL still_life_latency: got %0d expected 80", lat);
    end
    n_checks++;
    if (rc !== 7) begin
      n_fail++; $display("[TB] FAIL still_life_run_cycles: got %0d expected 7", rc);
    end
  endtask

  task automatic test_golden();
    logic [N-1:0] b, res, sin, exp_b;
    int lat, rc, rd, g;
    bit rdy, to, rdy_after;
    apply_command('0, 8'd3, 1'b1, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
    n_checks++;
    if (res !== '0 || to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL empty_board: got %h expected 0", res);
    end
    for (int i = 0; i < 6; i++) begin
      b = rand_board();
      g = int'($urandom_range(1, 4));
      exp_b = ref_life(b, g);
      apply_command(b, GEN_W'(g), 1'b1, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
      n_checks++;
      if (res !== exp_b) begin
        n_fail++; $display("[TB] FAIL golden_board[%0d]: got %h expected %h (start %h gens %0d)", i, res, exp_b, b, g);
      end
      n_checks++;
      if (lat !== 2 * N + g + 1 || rc !== g) begin
        n_fail++; $display("[TB] FAIL golden_timing[%0d]: got latency %0d run %0d expected %0d and %0d",
                           i, lat, rc, 2 * N + g + 1, g);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] b, res, sin, exp_b;
    int lat, rc, rd;
    bit rdy, to, rdy_after;
    b = rand_board();
    exp_b = ref_life(b, 2);
    apply_command(b, 8'd2, 1'b0, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_board !== exp_b || bus.cmd_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL backpressure_hold[%0d]: got valid %b board %h expected 1 and %h",
                           i, bus.res_valid, bus.res_board, exp_b);
      end
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_checks++;
    if ({bus.cmd_ready, bus.res_valid, busy} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL backpressure_release: got %b expected 100", {bus.cmd_ready, bus.res_valid, busy});
    end
  endtask

  task automatic test_ignore_busy();
    logic [N-1:0] b, res, sin, exp_b;
    int lat, rc, rd, extra_valid, extra_busy;
    bit rdy, to, rdy_after;
    b = rand_board();
    exp_b = ref_life(b, 2);
    apply_command(b, 8'd2, 1'b1, 10, res, lat, rc, rd, sin, rdy, to, rdy_after);
    n_checks++;
    if (res !== exp_b || lat !== 2 * N + 3) begin
      n_fail++; $display("[TB] FAIL ignore_busy_result: got %h latency %0d expected %h and %0d", res, lat, exp_b, 2 * N + 3);
    end
    extra_valid = 0; extra_busy = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) extra_valid++;
      if (busy !== 1'b0) extra_busy++;
    end
    n_checks++;
    if (extra_valid !== 0 || extra_busy !== 0) begin
      n_fail++; $display("[TB] FAIL ignore_busy_second: got %0d valid and %0d busy cycles expected 0", extra_valid, extra_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] b0, b1, res0, res1, sin;
    int lat, rc, rd;
    bit rdy0, rdy1, to, rdy_after;
    b0 = rand_board();
    b1 = rand_board();
    apply_command(b0, 8'd1, 1'b1, -1, res0, lat, rc, rd, sin, rdy0, to, rdy_after);
    apply_command(b1, 8'd4, 1'b1, -1, res1, lat, rc, rd, sin, rdy1, to, rdy_after);
    n_checks++;
    if (rdy1 !== 1'b1 || lat !== 2 * N + 5) begin
      n_fail++; $display("[TB] FAIL back_to_back_accept: got ready %b latency %0d expected 1 and %0d", rdy1, lat, 2 * N + 5);
    end
    n_checks++;
    if (res0 !== ref_life(b0, 1) || res1 !== ref_life(b1, 4)) begin
      n_fail++; $display("[TB] FAIL back_to_back_boards: got %h %h expected %h %h",
                         res0, res1, ref_life(b0, 1), ref_life(b1, 4));
    end
  endtask

  task automatic test_reset_mid_load();
    logic [N-1:0] b, res, sin;
    int lat, rc, rd;
    bit rdy, to, rdy_after;
    b = rand_board();
    bus.cmd_valid = 1'b1;
    bus.cmd_board = b;
    bus.cmd_gens  = 8'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (17) @(negedge clk);
    n_checks++;
    if (serial_in !== b[17]) begin
      n_fail++; $display("[TB] FAIL mid_load_bit17: got %b expected %b", serial_in, b[17]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.cmd_ready, bus.res_valid, busy, run, write_read_not, serial_in} !== 6'b100010) begin
      n_fail++; $display("[TB] FAIL mid_load_reset_outputs: got %b expected 100010",
                         {bus.cmd_ready, bus.res_valid, busy, run, write_read_not, serial_in});
    end
    apply_command(36'h6180, 8'd2, 1'b1, -1, res, lat, rc, rd, sin, rdy, to, rdy_after);
    n_checks++;
    if (res !== 36'h6180 || lat !== 2 * N + 3 || to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_load_recovery: got %h latency %0d expected 6180 and %0d", res, lat, 2 * N + 3);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.cmd_board = '0;
    bus.cmd_gens  = '0;
    dev_reg       = rand_board();
    test_reset();
    test_round_trip();
    test_still_life();
    test_golden();
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
